// File: rtl/iic_dsmod_pkg.sv
// Shared constants and helpers for the iic_dsmod delta-sigma modulator:
// OSR select encoding and reload values, dither LFSR seed/taps, saturating add.
package iic_dsmod_pkg;

    typedef enum logic [1:0] {
        OSR_SEL_32  = 2'd0,
        OSR_SEL_64  = 2'd1,
        OSR_SEL_128 = 2'd2,
        OSR_SEL_256 = 2'd3
    } osr_sel_e;

    localparam int unsigned OSR_32  = 32;
    localparam int unsigned OSR_64  = 64;
    localparam int unsigned OSR_128 = 128;
    localparam int unsigned OSR_256 = 256;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [7:0] osr_reload(input osr_sel_e sel);
        case (sel)
            OSR_SEL_32:  return 8'(OSR_32 - 1);
            OSR_SEL_64:  return 8'(OSR_64 - 1);
            OSR_SEL_128: return 8'(OSR_128 - 1);
            default:     return 8'(OSR_256 - 1);
        endcase
    endfunction

    // Sum is formed at 64 bits so no operand combination of an iw-bit
    // integrator can wrap before the clamp.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        iw);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (iw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (iw - 1));
        if (sum > hi)
            return hi;
        else if (sum < lo)
            return lo;
        else
            return sum;
    endfunction

endpackage

// File: rtl/iic_dsmod_sat_int.sv
// Single saturating integrator: q <= sat(q + a + b), with synchronous clear.
module iic_dsmod_sat_int
    import iic_dsmod_pkg::*;
#(
    parameter int unsigned IW = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [IW-1:0] a_i,
    input  logic signed [IW-1:0] b_i,
    output logic signed [IW-1:0] next_o,
    output logic signed [IW-1:0] q_o
);

    logic signed [IW-1:0] r_q;
    logic signed [IW-1:0] w_next;

    always_comb begin
        w_next = IW'(sat_add(64'(r_q), 64'(a_i) + 64'(b_i), IW));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i)
            r_q <= '0;
        else if (en_i)
            r_q <= w_next;
    end

    assign next_o = w_next;
    assign q_o    = r_q;

endmodule

// File: rtl/iic_dsmod.sv
// 1-bit first/second-order delta-sigma modulator with zero-order-hold sample fetch.
// Optional quantizer dither enabled by defining IIC_DSMOD_DITHER_EN.
module iic_dsmod
    import iic_dsmod_pkg::*;
#(
    parameter int unsigned BW = 16,
    parameter int unsigned IW = BW + 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic signed [BW-1:0] data_i,
    output logic                 data_rd_o,
    output logic                 ds_o,
    output logic                 ds_n_o,
    input  logic                 tst_dsmod_en_i,
    input  logic [1:0]           tst_dsmod_osr_i,
    input  logic                 tst_dsmod_order2_i
);

    localparam logic signed [IW-1:0] FB_MAG = IW'(2 ** (BW - 1));

    logic [7:0]           r_osr_cnt;
    logic signed [BW-1:0] r_x;
    logic                 r_ds_q;

    logic                 w_run;
    logic                 w_rd;
    logic signed [IW-1:0] w_x_ext;
    logic signed [IW-1:0] w_nfb;
    logic signed [IW-1:0] w_int1_q;
    logic signed [IW-1:0] w_int1_next;
    logic signed [IW-1:0] w_int2_next;
    logic signed [IW-1:0] w_int2_q_unused;
    logic signed [IW:0]   w_dith;
    logic signed [IW:0]   w_qin;

    assign w_run   = rst_n_i & tst_dsmod_en_i;
    assign w_rd    = w_run && (r_osr_cnt == '0);
    assign w_x_ext = IW'(r_x);
    assign w_nfb   = r_ds_q ? -FB_MAG : FB_MAG;

    iic_dsmod_sat_int #(.IW(IW)) u_int1 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (~tst_dsmod_en_i),
        .en_i    (tst_dsmod_en_i),
        .a_i     (w_x_ext),
        .b_i     (w_nfb),
        .next_o  (w_int1_next),
        .q_o     (w_int1_q)
    );

    // Second stage integrates the registered first-stage value, not its next value
    iic_dsmod_sat_int #(.IW(IW)) u_int2 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (~tst_dsmod_en_i | ~tst_dsmod_order2_i),
        .en_i    (tst_dsmod_en_i),
        .a_i     (w_int1_q),
        .b_i     (w_nfb),
        .next_o  (w_int2_next),
        .q_o     (w_int2_q_unused)
    );

`ifdef IIC_DSMOD_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i) begin
        if (!w_run)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
    end

    assign w_dith = {{(IW - 2){r_lfsr[2]}}, r_lfsr[2:0]};
`else
    assign w_dith = '0;
`endif

    // One guard bit so dither near full scale cannot flip the sign decision
    always_comb begin
        w_qin = tst_dsmod_order2_i ? (IW + 1)'(w_int2_next) : (IW + 1)'(w_int1_next);
        w_qin = w_qin + w_dith;
    end

    always_ff @(posedge clk_i) begin
        if (!w_run) begin
            r_osr_cnt <= '0;
            r_x       <= '0;
            r_ds_q    <= 1'b0;
        end else begin
            if (w_rd) begin
                r_osr_cnt <= osr_reload(osr_sel_e'(tst_dsmod_osr_i));
                r_x       <= data_i;
            end else begin
                r_osr_cnt <= r_osr_cnt - 8'd1;
            end
            r_ds_q <= ~w_qin[IW];
        end
    end

    assign data_rd_o = w_rd;
    assign ds_o      = r_ds_q;
    assign ds_n_o    = w_run & ~r_ds_q;

endmodule

// File: tb/tb_iic_dsmod.sv
// Directed self-checking bench for iic_dsmod: cycle vectors plus strobe,
// density, saturation and disable/reset sequences.
module tb_iic_dsmod;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        ord2;
        logic [1:0]  osr;
        logic [15:0] data;
        logic        rd;
        logic        ds;
        logic        dsn;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] data;
    logic               data_rd_o;
    logic               ds_o;
    logic               ds_n_o;
    logic               en;
    logic [1:0]         osr;
    logic               ord2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iic_dsmod #(.BW(16), .IW(20)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .data_i             (data),
        .data_rd_o          (data_rd_o),
        .ds_o               (ds_o),
        .ds_n_o             (ds_n_o),
        .tst_dsmod_en_i     (en),
        .tst_dsmod_osr_i    (osr),
        .tst_dsmod_order2_i (ord2)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_to_strobe(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
            if (data_rd_o) break;
        end
    endtask

    task automatic run_dc(input logic o2, input logic [15:0] d, input logic [1:0] os,
                          input int ncyc, output int ones, output int reads);
        en = 1'b0;
        tick();
        ord2  = o2;
        data  = d;
        osr   = os;
        en    = 1'b1;
        ones  = 0;
        reads = 0;
        repeat (ncyc) begin
            @(negedge clk);
            ones  += int'(ds_o);
            reads += int'(data_rd_o);
            tick();
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic o2,
                                input logic [15:0] d, input logic rd, input logic ds,
                                input logic dsn);
        vec_t v;
        v.rst_n = r; v.en = e; v.ord2 = o2; v.osr = 2'd0; v.data = d;
        v.rd = rd; v.ds = ds; v.dsn = dsn;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        logic o1_ds[9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
        logic o2_ds[10] = '{0, 1, 1, 1, 0, 1, 1, 0, 1, 1};
        int n, ones, reads, wraps, prev1, prev2, v1, v2;
        bit saw_max;

        rst_n = 1'b0; en = 1'b0; ord2 = 1'b0; osr = 2'd0; data = '0;
        repeat (2) tick();

        // Reset held with enable high, then +0.5 FS first order, disable, second order
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 16'h4000, 0, 0, 0));
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(1, 1, 0, 16'h4000, (i == 0), o1_ds[i], ~o1_ds[i]));
        tbl.push_back(mk(1, 0, 0, 16'h4000, 0, 1, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 1, 1, 16'h4000, (i == 0), o2_ds[i], ~o2_ds[i]));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; en = tbl[i].en; ord2 = tbl[i].ord2;
            osr = tbl[i].osr; data = tbl[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d_rd", i), data_rd_o, tbl[i].rd);
            chk($sformatf("vec%0d_ds", i), ds_o, tbl[i].ds);
            chk($sformatf("vec%0d_dsn", i), ds_n_o, tbl[i].dsn);
            tick();
        end

        // Strobe spacing and OSR change taking effect only at reload
        rst_n = 1'b0; en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1; en = 1'b1; osr = 2'd0; ord2 = 1'b0; data = '0;
        @(negedge clk);
        chk("first_strobe", data_rd_o, 1);
        count_to_strobe(64, n);   chk("osr32_gap_a", n, 32);
        count_to_strobe(64, n);   chk("osr32_gap_b", n, 32);
        repeat (10) tick();
        osr = 2'd3;
        count_to_strobe(64, n);   chk("osr_change_gap", n, 22);
        count_to_strobe(600, n);  chk("osr256_gap", n, 256);

        // DC accuracy over 64 samples at OSR 64
        run_dc(1, 16'h4000, 2'd1, 4096, ones, reads);
        chk_rng("dc_half_o2_ones", ones, 3031, 3113);
        chk("dc_half_o2_reads", reads, 64);
        run_dc(1, 16'h0000, 2'd1, 4096, ones, reads);
        chk_rng("dc_zero_o2_ones", ones, 2007, 2089);
        run_dc(0, 16'hC000, 2'd1, 4096, ones, reads);
        chk_rng("dc_neg_half_o1_ones", ones, 983, 1065);

        // Full-scale input: integrators must clamp, never wrap
        en = 1'b0;
        tick();
        ord2 = 1'b1; data = 16'sh7FFF; osr = 2'd0; en = 1'b1;
        ones = 0; wraps = 0; saw_max = 1'b0; prev1 = 0; prev2 = 0;
        repeat (640) begin
            @(negedge clk);
            ones += int'(ds_o);
            v1 = int'(dut.u_int1.r_q);
            v2 = int'(dut.u_int2.r_q);
            if ((prev1 > 262144 && v1 < -262144) || (prev1 < -262144 && v1 > 262144)) wraps++;
            if ((prev2 > 262144 && v2 < -262144) || (prev2 < -262144 && v2 > 262144)) wraps++;
            if (v2 == 524287) saw_max = 1'b1;
            prev1 = v1; prev2 = v2;
            tick();
        end
        chk("sat_no_wrap", wraps, 0);
        chk("sat_reached_max", saw_max, 1);
        chk_rng("sat_ones", ones, 621, 640);

        // One-cycle disable mid-sample
        data = 16'h4000; osr = 2'd0;
        repeat (20) tick();
        en = 1'b0;
        @(negedge clk);
        chk("dis_rd", data_rd_o, 0);
        chk("dis_dsn", ds_n_o, 0);
        tick();
        en = 1'b1;
        @(negedge clk);
        chk("reen_ds", ds_o, 0);
        chk("reen_rd", data_rd_o, 1);
        chk("reen_int1", dut.u_int1.r_q, 0);
        chk("reen_int2", dut.u_int2.r_q, 0);

        // Order switch clears the second integrator
        repeat (6) tick();
        ord2 = 1'b0;
        tick();
        @(negedge clk);
        chk("order1_int2_clear", dut.u_int2.r_q, 0);
        ord2 = 1'b1;
        tick();

        // Reset mid-sample
        repeat (5) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rd", data_rd_o, 0);
        chk("rst_dsn", ds_n_o, 0);
        tick();
        @(negedge clk);
        chk("rst_ds", ds_o, 0);
        chk("rst_int1", dut.u_int1.r_q, 0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
